// File: rtl/ad_ip_jesd204_tpl_dac_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_pkg
// Description : Shared types and constants for the TPL DAC link controller.
//               Build option: TPL_DAC_UNDERFLOW_CNT_EN enables the underflow
//               counter in the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package ad_ip_jesd204_tpl_dac_pkg;

  localparam int UNDERFLOW_CNT_WIDTH = 32;

  localparam logic [UNDERFLOW_CNT_WIDTH-1:0] c_cnt_one = UNDERFLOW_CNT_WIDTH'(1);

  // Streaming controller life cycle: idle -> armed -> start delay -> running
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [UNDERFLOW_CNT_WIDTH-1:0] sat_inc(
    input logic [UNDERFLOW_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : (v + c_cnt_one);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_link_ctrl_if
// Description : DMA request/data and JESD204 link beat handshake bundle.
//               master = link controller, slave = DMA source / link sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface ad_ip_jesd204_tpl_dac_link_ctrl_if #(
  parameter int NUM_CHANNELS    = 4,
  parameter int LINK_DATA_WIDTH = 128
);

  logic [NUM_CHANNELS-1:0]    dac_valid;
  logic [LINK_DATA_WIDTH-1:0] dac_ddata;
  logic                       link_valid;
  logic                       link_ready;
  logic [LINK_DATA_WIDTH-1:0] link_data;

  modport master (
    output dac_valid,
    input  dac_ddata,
    output link_valid,
    input  link_ready,
    output link_data
  );

  modport slave (
    input  dac_valid,
    output dac_ddata,
    input  link_valid,
    output link_ready,
    input  link_data
  );

endinterface
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_link_ctrl_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_skid_buf
// Description : Two-entry buffer: an output (head) register backed by one skid
//               register. Push and pop may coincide; synchronous flush wins
//               over both.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_skid_buf #(
  parameter int DATA_WIDTH = 128
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_flush,
  input  wire logic                  i_push,
  input  wire logic                  i_pop,
  input  wire logic [DATA_WIDTH-1:0] i_data,
  output logic      [DATA_WIDTH-1:0] o_data,
  output logic                       o_full,
  output logic                       o_empty
);

  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_pop;

  // A pop on an empty buffer has nothing to remove
  assign w_pop = i_pop & (r_count != 2'd0);

  // Occupancy and data movement; the head always holds the oldest beat
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= i_data;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_skid  <= i_data;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head <= r_skid;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new beat lands behind whatever remains
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_skid;
            r_skid <= i_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ad_ip_jesd204_tpl_dac_link_ctrl
// Description : Streaming controller between the DMA sample source and the
//               JESD204 link of the TPL DAC. Holds zero idle frames on the
//               link until a programmed start instant, then streams DMA beats
//               through a 2-entry skid buffer with a real valid/ready
//               handshake and per-channel request gating.
//               Build option: define TPL_DAC_UNDERFLOW_CNT_EN to include the
//               saturating underflow counter (otherwise tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module ad_ip_jesd204_tpl_dac_link_ctrl
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int NUM_CHANNELS     = 4,
  parameter int LINK_DATA_WIDTH  = 128,
  parameter int SYNC_DELAY_WIDTH = 16
) (
  input  wire logic                           clk,
  input  wire logic                           reset,
  input  wire logic                           arm,
  input  wire logic                           disarm,
  input  wire logic                           sw_sync,
  input  wire logic                           stop,
  input  wire logic                           sync_in,
  input  wire logic [SYNC_DELAY_WIDTH-1:0]    sync_delay,
  input  wire logic [NUM_CHANNELS-1:0]        enable,
  ad_ip_jesd204_tpl_dac_link_ctrl_if.master   bus,
  output logic                                sync_armed,
  output logic                                running,
  output logic [UNDERFLOW_CNT_WIDTH-1:0]      underflow_cnt
);

  localparam int CH_DATA_WIDTH = LINK_DATA_WIDTH / NUM_CHANNELS;

  localparam logic [SYNC_DELAY_WIDTH-1:0] c_dly_one = SYNC_DELAY_WIDTH'(1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [SYNC_DELAY_WIDTH-1:0] r_dly_cnt;
  logic [SYNC_DELAY_WIDTH-1:0] w_dly_cnt_nxt;
  logic                        r_sync_in_d;
  logic                        r_link_valid;

  logic                        w_sync_rise;
  logic                        w_run;
  logic                        w_req;
  logic                        w_pop;
  logic                        w_flush;
  logic                        w_buf_full;
  logic                        w_buf_empty;
  logic [LINK_DATA_WIDTH-1:0]  w_masked;
  logic [LINK_DATA_WIDTH-1:0]  w_head;

  // Delayed copy of the external sync level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_in_d <= 1'b0;
    end else begin
      r_sync_in_d <= sync_in;
    end
  end

  assign w_sync_rise = sync_in & ~r_sync_in_d;

  // The link always sees a valid beat (data or zero idle frame) outside reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_link_valid <= 1'b0;
    end else begin
      r_link_valid <= 1'b1;
    end
  end

  // State and start-delay counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dly_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dly_cnt <= w_dly_cnt_nxt;
    end
  end

  // Next-state logic; disarm outranks any start request in the same cycle,
  // and the delay counter is loaded on every entry into DELAY
  always_comb begin
    w_state_nxt   = r_state;
    w_dly_cnt_nxt = r_dly_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!disarm) begin
          if (sw_sync) begin
            w_state_nxt   = ST_DELAY;
            w_dly_cnt_nxt = sync_delay;
          end else if (arm) begin
            w_state_nxt = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sync_rise || sw_sync) begin
          w_state_nxt   = ST_DELAY;
          w_dly_cnt_nxt = sync_delay;
        end
      end
      ST_DELAY: begin
        if (disarm) begin
          w_state_nxt = ST_IDLE;
        end else if (r_dly_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_dly_cnt_nxt = r_dly_cnt - c_dly_one;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_run      = (r_state == ST_RUN);
  assign running    = w_run;
  assign sync_armed = (r_state == ST_ARMED) || (r_state == ST_DELAY);

  // Pop whenever the link takes a beat that actually carries buffered data;
  // leaving RUN throws away everything still buffered
  assign w_pop   = w_run & r_link_valid & bus.link_ready & ~w_buf_empty;
  assign w_flush = w_run & stop;

  // Request only if the buffer can absorb one more beat after this pop
  assign w_req         = w_run & (~w_buf_full | w_pop);
  assign bus.dac_valid = {NUM_CHANNELS{w_req}} & enable;

  // Disabled channels contribute zero samples to the captured beat
  for (genvar g_ch = 0; g_ch < NUM_CHANNELS; g_ch++) begin : g_mask
    assign w_masked[g_ch*CH_DATA_WIDTH +: CH_DATA_WIDTH] =
      enable[g_ch] ? bus.dac_ddata[g_ch*CH_DATA_WIDTH +: CH_DATA_WIDTH]
                   : {CH_DATA_WIDTH{1'b0}};
  end

  ad_ip_jesd204_tpl_dac_skid_buf #(
    .DATA_WIDTH (LINK_DATA_WIDTH)
  ) u_skid_buf (
    .clk     (clk),
    .rst     (reset),
    .i_flush (w_flush),
    .i_push  (w_req),
    .i_pop   (w_pop),
    .i_data  (w_masked),
    .o_data  (w_head),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );

  // Idle frames are zero; an empty buffer in RUN also sends zeros
  assign bus.link_valid = r_link_valid;
  assign bus.link_data  = (w_run && !w_buf_empty) ? w_head : '0;

`ifdef TPL_DAC_UNDERFLOW_CNT_EN
  logic                           w_underflow;
  logic [UNDERFLOW_CNT_WIDTH-1:0] r_underflow_cnt;

  // The link asked for a beat in RUN and the buffer had nothing to give
  assign w_underflow = w_run & bus.link_ready & w_buf_empty;

  // Saturating underflow event counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow_cnt <= '0;
    end else if (w_underflow) begin
      r_underflow_cnt <= sat_inc(r_underflow_cnt);
    end
  end

  assign underflow_cnt = r_underflow_cnt;
`else
  assign underflow_cnt = '0;
`endif

endmodule
`default_nettype wire
